// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: operation encoding and slice geometry helpers.
package arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // True when the carry chain divides into equal, non-empty slices.
  function automatic bit slice_cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Bits per slice; falls back to 1 on a bad configuration so that
  // declarations stay legal until the elaboration check fires.
  function automatic int slice_width(input int width, input int stages);
    if (!slice_cfg_ok(width, stages)) return 1;
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple slice of the pipelined carry chain.
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  // Slice sum; the carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    c_msb_in  = s[SW-1] ^ a[SW-1] ^ b[SW-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit with the carry chain split into STAGES
// registered slices behind a valid/ready handshake; the whole pipe stalls
// under backpressure.
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!slice_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $fatal(1, "pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
  end

  logic stall;
  op_e  op;

  // Index k is stage k: stage 0 holds captured operands, stage k>0 holds
  // result slices 0..k-1 plus the carry out of slice k-1.
  logic [STAGES:0]  v_q, v_d;
  logic [STAGES:0]  c_q, c_d;
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [WIDTH-1:0] s_d [STAGES+1];
  // Operand skew registers; stage STAGES no longer needs operands.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic             ovf_q, ovf_d;

  logic [STAGES-1:0][SW-1:0] sl_s;
  logic [STAGES-1:0]         sl_c;
  logic                      sl_m [STAGES];

  // Global stall: the result at the output is not being taken.
  always_comb begin
    stall    = v_q[STAGES] & ~out_ready;
    in_ready = ~stall;
  end

  // Slice g works on stage g's operands and produces stage g+1's data.
  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    adder_slice #(.SW(SW)) u_slice (
      .a        (a_q[g][g*SW +: SW]),
      .b        (b_q[g][g*SW +: SW]),
      .cin      (c_q[g]),
      .s        (sl_s[g]),
      .cout     (sl_c[g]),
      .c_msb_in (sl_m[g])
    );
  end

  // Next-state for every stage: capture, slice add, skew and carry-forward.
  always_comb begin
    op      = op_e'(sub_in);
    v_d[0]  = in_valid & ~stall;
    a_d[0]  = a_in;
    b_d[0]  = (op == OP_SUB) ? ~b_in : b_in;
    c_d[0]  = (op == OP_SUB) ? 1'b1 : cin_in;
    s_d[0]  = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int unsigned k = 1; k <= STAGES; k++) begin
      v_d[k]                  = v_q[k-1];
      c_d[k]                  = sl_c[k-1];
      s_d[k]                  = s_q[k-1];
      s_d[k][(k-1)*SW +: SW]  = sl_s[k-1];
    end
    ovf_d = sl_m[STAGES-1] ^ sl_c[STAGES-1];
  end

  // Pipeline registers: cleared by reset, frozen as a whole while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k <= STAGES; k++) s_q[k] <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k <= STAGES; k++) s_q[k] <= s_d[k];
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign sum_out   = s_q[STAGES];
  assign cout_out  = c_q[STAGES];
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (16/4 and 1/1 builds).
module tb_pipelined_adder;

  localparam int W   = 16;
  localparam int S   = 4;
  localparam int LAT = S + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin_in, sub_in;
  logic         out_valid, out_ready, cout_out, ovf_out;
  logic [W-1:0] a_in, b_in, sum_out;

  logic in_valid1, in_ready1, a1, b1, cin1, sub1;
  logic out_valid1, out_ready1, sum1, cout1, ovf1;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in), .sub_in(sub_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out)
  );

  pipelined_adder #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a1), .b_in(b1), .cin_in(cin1), .sub_in(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum_out(sum1), .cout_out(cout1), .ovf_out(ovf1)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t        exp_q[$];
  int unsigned nvec = 0, nerr = 0;
  int unsigned n_acc = 0, n_cons = 0, n_both = 0;
  logic        prev_stall = 1'b0, prev_rst = 1'b1;
  logic [W-1:0] prev_sum = '0;
  logic        prev_cout = 1'b0, prev_ovf = 1'b0;
  logic        last_acc = 1'b0;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int ua, ub, sa, sb, full, sfull;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      full   = ua - ub;
      sfull  = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + int'(cin);
      sfull  = sa + sb + int'(cin);
      r.cout = (full >= (1 << W));
    end
    r.sum = full[W-1:0];
    r.ovf = (sfull > ((1 << (W-1)) - 1)) || (sfull < -(1 << (W-1)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Per-cycle scoreboard, handshake and hold checks for the 16-bit DUT.
  task automatic sample();
    logic acc, cons;
    res_t e;
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (prev_stall && !prev_rst) begin
      chk("hold_sum",  32'(sum_out),  32'(prev_sum));
      chk("hold_cout", 32'(cout_out), 32'(prev_cout));
      chk("hold_ovf",  32'(ovf_out),  32'(prev_ovf));
    end
    if (cons) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got result 0x%0h, expected no beat", sum_out);
      end else begin
        e = exp_q.pop_front();
        chk("sum",  32'(sum_out),  32'(e.sum));
        chk("cout", 32'(cout_out), 32'(e.cout));
        chk("ovf",  32'(ovf_out),  32'(e.ovf));
      end
      n_cons++;
    end
    if (rst) exp_q.delete();
    else if (acc) begin
      exp_q.push_back(model(a_in, b_in, cin_in, sub_in));
      n_acc++;
    end
    if (acc && cons && !rst) n_both++;
    last_acc   = acc && !rst;
    prev_stall = out_valid && !out_ready;
    prev_rst   = rst;
    prev_sum   = sum_out;
    prev_cout  = cout_out;
    prev_ovf   = ovf_out;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat();
    a_in   = W'($urandom);
    b_in   = W'($urandom);
    cin_in = 1'($urandom);
    sub_in = 1'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    nerr++;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    int unsigned c0, b0, a0;
    logic [2:0]  t;
    int          tot, sf;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum_out),   32'd0);
    chk("rst_cout",      32'(cout_out),  32'd0);
    chk("rst_ovf",       32'(ovf_out),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);

    // Directed vectors, one at a time, with exact latency.
    for (int i = 0; i < 9; i++) begin
      a_in = tbl[i].a; b_in = tbl[i].b; cin_in = tbl[i].cin; sub_in = tbl[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'(c == LAT));
        if (c == LAT) begin
          chk("tbl_sum",  32'(sum_out),  32'(tbl[i].sum));
          chk("tbl_cout", 32'(cout_out), 32'(tbl[i].cout));
          chk("tbl_ovf",  32'(ovf_out),  32'(tbl[i].ovf));
        end
        sample();
        @(posedge clk);
        #1;
      end
    end

    // Back-to-back random beats: first result after LAT cycles, then one per cycle.
    c0 = n_cons;
    b0 = n_both;
    for (int i = 0; i < 25; i++) begin
      if (i < 20) begin
        new_beat();
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      tick();
      chk("throughput_count", n_cons - c0, (i >= LAT) ? 32'(i - LAT + 1) : 32'd0);
    end
    chk("accept_and_consume", n_both - b0, 32'd15);

    // Backpressure: stall 6 cycles once results are flowing.
    a0 = n_acc;
    new_beat();
    in_valid = 1'b1;
    for (int n = 0; n < 10 && !out_valid; n++) begin
      tick();
      if (last_acc) new_beat();
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("bp_stalled_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stalled_valid",    32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 30 && (n_acc - a0) < 12; n++) begin
      tick();
      if (last_acc) new_beat();
    end
    chk("bp_accepted", n_acc - a0, 32'd12);
    drain();

    // Random valid/ready traffic.
    in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        new_beat();
      end
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    // Reset with three beats in flight; the beat offered during reset is dropped.
    for (int n = 0; n < 3; n++) begin
      new_beat();
      in_valid = 1'b1;
      tick();
    end
    new_beat();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum",       32'(sum_out),   32'd0);
    chk("midrst_cout",      32'(cout_out),  32'd0);
    chk("midrst_ovf",       32'(ovf_out),   32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // WIDTH=1, STAGES=1: full-adder truth table with 2-cycle latency.
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      a1 = t[2]; b1 = t[1]; cin1 = t[0]; sub1 = 1'b0;
      tot = int'(a1) + int'(b1) + int'(cin1);
      sf  = -int'(a1) - int'(b1) + int'(cin1);
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("fa_early_valid", 32'(out_valid1), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("fa_valid", 32'(out_valid1), 32'd1);
      chk("fa_sum",   32'(sum1),  32'(tot % 2));
      chk("fa_cout",  32'(cout1), 32'(tot / 2));
      chk("fa_ovf",   32'(ovf1),  32'((sf > 0) || (sf < -1)));
      @(posedge clk);
      #1;
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
